// File: rtl/bullet_pkg.sv
// Shared bullet/playfield definitions used by the bullet controller, enemy controller and renderer.
package bullet_pkg;

   localparam int SCREEN_W     = 640;
   localparam int SCREEN_H     = 480;
   localparam int SPRITE_W     = 32;
   localparam int BULLET_COUNT = 8;
   localparam int COORD_W      = 10;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      logic   active;
      coord_t x;
      coord_t y;
   } bullet_t;

   function automatic logic [3:0] popcount8(input logic [BULLET_COUNT-1:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < BULLET_COUNT; i++) c = c + {3'b000, v[i]};
      return c;
   endfunction

endpackage

// File: rtl/bullet_slot_alloc.sv
// Lowest-index free slot finder for the bullet pool (purely combinational).
module bullet_slot_alloc
   import bullet_pkg::*;
(
   input  logic [BULLET_COUNT-1:0] active,
   output logic                    free,
   output logic [2:0]              idx
);

   // NOTE: defaults first, so every path assigns every output and no latch is inferred.
   always_comb begin
      free = 1'b0;
      idx  = 3'd0;
      for (int i = BULLET_COUNT - 1; i >= 0; i--) begin
         if (!active[i]) begin
            free = 1'b1;
            idx  = 3'(i);
         end
      end
   end

endmodule

// File: rtl/bullet_controller.sv
// Player bullet pool: spawn on fire with cooldown, move up per frame, retire on hit or top edge.
module bullet_controller
   import bullet_pkg::*;
#(
   parameter int BULLET_SPEED  = 4,
   parameter int FIRE_COOLDOWN = 8,
   parameter int X_OFFSET      = 15
) (
   input  logic               clk25,
   input  logic               reset_n,
   input  logic               frame_tick,
   input  logic               fire,
   input  logic [COORD_W-1:0] player_x,
   input  logic [COORD_W-1:0] player_y,
   input  logic [7:0]         bullet_hit,
   output logic [COORD_W-1:0] bullet_x0, bullet_x1, bullet_x2, bullet_x3,
   output logic [COORD_W-1:0] bullet_x4, bullet_x5, bullet_x6, bullet_x7,
   output logic [COORD_W-1:0] bullet_y0, bullet_y1, bullet_y2, bullet_y3,
   output logic [COORD_W-1:0] bullet_y4, bullet_y5, bullet_y6, bullet_y7,
   output logic               bullet_active0, bullet_active1, bullet_active2, bullet_active3,
   output logic               bullet_active4, bullet_active5, bullet_active6, bullet_active7,
   output logic               shot_fired,
   output logic [3:0]         active_count
);

   localparam coord_t     SPEED_C    = coord_t'(BULLET_SPEED);
   localparam coord_t     XOFF_C     = coord_t'(X_OFFSET);
   localparam logic [4:0] COOLDOWN_C = 5'(FIRE_COOLDOWN);

   bullet_t                 slot_q [BULLET_COUNT];
   bullet_t                 slot_d [BULLET_COUNT];
   logic [BULLET_COUNT-1:0] active_q;
   logic [BULLET_COUNT-1:0] active_d;
   logic [4:0]              cooldown_q, cooldown_d;
   logic                    free;
   logic [2:0]              free_idx;
   logic                    spawn;

   always_comb begin
      for (int j = 0; j < BULLET_COUNT; j++) active_q[j] = slot_q[j].active;
   end

   bullet_slot_alloc u_alloc (
      .active (active_q),
      .free   (free),
      .idx    (free_idx)
   );

   assign spawn = fire && (cooldown_q == 5'd0) && free;

   // Spawn only targets a slot inactive at cycle start, so it never collides with hit/move.
   always_comb begin
      for (int j = 0; j < BULLET_COUNT; j++) begin
         slot_d[j] = slot_q[j];
         if (bullet_hit[j] && slot_q[j].active) begin
            slot_d[j].active = 1'b0;
         end else if (frame_tick && slot_q[j].active) begin
            if (slot_q[j].y < SPEED_C) slot_d[j].active = 1'b0;
            else                       slot_d[j].y      = slot_q[j].y - SPEED_C;
         end else if (spawn && (free_idx == 3'(j))) begin
            slot_d[j].active = 1'b1;
            slot_d[j].x      = player_x + XOFF_C;
            slot_d[j].y      = player_y;
         end
         active_d[j] = slot_d[j].active;
      end
   end

   always_comb begin
      if (spawn)                                  cooldown_d = COOLDOWN_C;
      else if (frame_tick && cooldown_q != 5'd0)  cooldown_d = cooldown_q - 5'd1;
      else                                        cooldown_d = cooldown_q;
   end

   // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         for (int j = 0; j < BULLET_COUNT; j++) slot_q[j] <= '0;
         cooldown_q   <= '0;
         shot_fired   <= 1'b0;
         active_count <= '0;
      end else begin
         for (int j = 0; j < BULLET_COUNT; j++) slot_q[j] <= slot_d[j];
         cooldown_q   <= cooldown_d;
         shot_fired   <= spawn;
         active_count <= popcount8(active_d);
      end
   end

   assign bullet_x0 = slot_q[0].x;  assign bullet_y0 = slot_q[0].y;  assign bullet_active0 = slot_q[0].active;
   assign bullet_x1 = slot_q[1].x;  assign bullet_y1 = slot_q[1].y;  assign bullet_active1 = slot_q[1].active;
   assign bullet_x2 = slot_q[2].x;  assign bullet_y2 = slot_q[2].y;  assign bullet_active2 = slot_q[2].active;
   assign bullet_x3 = slot_q[3].x;  assign bullet_y3 = slot_q[3].y;  assign bullet_active3 = slot_q[3].active;
   assign bullet_x4 = slot_q[4].x;  assign bullet_y4 = slot_q[4].y;  assign bullet_active4 = slot_q[4].active;
   assign bullet_x5 = slot_q[5].x;  assign bullet_y5 = slot_q[5].y;  assign bullet_active5 = slot_q[5].active;
   assign bullet_x6 = slot_q[6].x;  assign bullet_y6 = slot_q[6].y;  assign bullet_active6 = slot_q[6].active;
   assign bullet_x7 = slot_q[7].x;  assign bullet_y7 = slot_q[7].y;  assign bullet_active7 = slot_q[7].active;

endmodule

// File: tb/tb_bullet_controller.sv
// Directed self-checking bench for bullet_controller with hand-computed expectations.
module tb_bullet_controller;

   logic       clk25 = 1'b0;
   logic       reset_n;
   logic       frame_tick;
   logic       fire;
   logic [9:0] player_x, player_y;
   logic [7:0] bullet_hit;
   logic [9:0] bx [8];
   logic [9:0] by [8];
   logic [7:0] act;
   logic       shot_fired;
   logic [3:0] active_count;

   int passed = 0;
   int total  = 0;

   always #20 clk25 = ~clk25;

   bullet_controller dut (
      .clk25          (clk25),
      .reset_n        (reset_n),
      .frame_tick     (frame_tick),
      .fire           (fire),
      .player_x       (player_x),
      .player_y       (player_y),
      .bullet_hit     (bullet_hit),
      .bullet_x0 (bx[0]), .bullet_x1 (bx[1]), .bullet_x2 (bx[2]), .bullet_x3 (bx[3]),
      .bullet_x4 (bx[4]), .bullet_x5 (bx[5]), .bullet_x6 (bx[6]), .bullet_x7 (bx[7]),
      .bullet_y0 (by[0]), .bullet_y1 (by[1]), .bullet_y2 (by[2]), .bullet_y3 (by[3]),
      .bullet_y4 (by[4]), .bullet_y5 (by[5]), .bullet_y6 (by[6]), .bullet_y7 (by[7]),
      .bullet_active0 (act[0]), .bullet_active1 (act[1]), .bullet_active2 (act[2]),
      .bullet_active3 (act[3]), .bullet_active4 (act[4]), .bullet_active5 (act[5]),
      .bullet_active6 (act[6]), .bullet_active7 (act[7]),
      .shot_fired     (shot_fired),
      .active_count   (active_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk25);
      #1;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   initial begin
      reset_n    = 1'b0;
      frame_tick = 1'b0;
      fire       = 1'b0;
      player_x   = 10'd300;
      player_y   = 10'd440;
      bullet_hit = 8'h00;
      #50;
      check("reset_active", act, 8'h00);
      check("reset_count", active_count, 0);
      check("reset_shot", shot_fired, 0);
      check("reset_x0", bx[0], 0);
      check("reset_y0", by[0], 0);
      reset_n = 1'b1;
      step();

      // 1: single shot
      fire = 1'b1;
      step();
      fire = 1'b0;
      check("t1_active", act, 8'h01);
      check("t1_x0", bx[0], 315);
      check("t1_y0", by[0], 440);
      check("t1_shot", shot_fired, 1);
      check("t1_count", active_count, 1);
      step();
      check("t1_shot_pulse", shot_fired, 0);

      // 2: flight to the top edge
      repeat (10) begin tick(); step(); end
      check("t2_y_400", by[0], 400);
      repeat (100) begin tick(); step(); end
      check("t2_y_0", by[0], 0);
      check("t2_still_live", act[0], 1);
      tick();
      check("t2_exit_active", act[0], 0);
      check("t2_exit_count", active_count, 0);
      check("t2_no_wrap", by[0], 0);

      // 3: auto-repeat at cooldown rate, then pool full
      fire = 1'b1;
      step();
      check("t3_spawn0", act, 8'h01);
      check("t3_shot0", shot_fired, 1);
      for (int k = 1; k < 8; k++) begin
         repeat (7) begin tick(); step(); end
         check($sformatf("t3_hold_count%0d", k), active_count, k);
         tick();
         check($sformatf("t3_early_shot%0d", k), shot_fired, 0);
         step();
         check($sformatf("t3_shot%0d", k), shot_fired, 1);
         check($sformatf("t3_slot%0d", k), act[k], 1);
         check($sformatf("t3_count%0d", k), active_count, k + 1);
      end
      repeat (8) begin tick(); step(); end
      check("t3_full_shot", shot_fired, 0);
      check("t3_full_count", active_count, 8);
      fire = 1'b0;
      // slot k sits at 440 - 4*(64 - 8k) = 184 + 32k
      check("t3_y0", by[0], 184);
      check("t3_y7", by[7], 408);

      // 4: hit on slot 2, hit on inactive slot, respawn into slot 2
      bullet_hit = 8'h04;
      step();
      bullet_hit = 8'h00;
      check("t4_hit_active", act, 8'hFB);
      check("t4_hit_count", active_count, 7);
      bullet_hit = 8'h04;
      step();
      bullet_hit = 8'h00;
      check("t4_inactive_hit", act, 8'hFB);
      check("t4_inactive_count", active_count, 7);
      fire = 1'b1;
      step();
      fire = 1'b0;
      check("t4_respawn", act, 8'hFF);
      check("t4_respawn_shot", shot_fired, 1);
      check("t4_respawn_x2", bx[2], 315);
      check("t4_respawn_y2", by[2], 440);

      // 5: hit and tick together
      bullet_hit = 8'h02;
      frame_tick = 1'b1;
      step();
      bullet_hit = 8'h00;
      frame_tick = 1'b0;
      check("t5_active", act, 8'hFD);
      check("t5_y1_hold", by[1], 216);
      check("t5_y0_move", by[0], 180);
      check("t5_y2_move", by[2], 436);
      check("t5_y7_move", by[7], 404);
      check("t5_count", active_count, 7);

      // 6: async reset mid-flight with 5 live, fire held through reset
      bullet_hit = 8'h60;
      step();
      bullet_hit = 8'h00;
      check("t6_five_live", active_count, 5);
      fire = 1'b1;
      #5 reset_n = 1'b0;
      #1;
      check("t6_async_active", act, 8'h00);
      check("t6_async_count", active_count, 0);
      @(negedge clk25);
      reset_n = 1'b1;
      step();
      check("t6_first_spawn", act, 8'h01);
      check("t6_first_shot", shot_fired, 1);
      check("t6_first_x0", bx[0], 315);
      fire = 1'b0;

      // x wraps at 10 bits: 1020 + 15 = 11
      player_x = 10'd1020;
      repeat (8) begin tick(); step(); end
      fire = 1'b1;
      step();
      fire = 1'b0;
      check("wrap_active", act, 8'h03);
      check("wrap_x1", bx[1], 11);
      check("wrap_y1", by[1], 440);
      check("wrap_y0", by[0], 408);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
